seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
// Time-multiplexed 4-digit seven-segment scan driver fed by the bus peripheral write at 0x40000010.
// Latches a 16-bit hex value (4 nibbles) plus decimal points into a shadow register.
// Commits the shadow register only at a scan-frame boundary, so a frame never shows a mix of old and new digits.
// Drives the board anodes and segments directly; optional leading-zero blanking.
// PARAMETERS
// CLK_DIV   100000  clocks per digit slot (prescaler period), >=2
// PORTS
// clk         in   1   system clock
// reset       in   1   asynchronous, active-low reset
// load        in   1   1-cycle strobe: capture value/dp into shadow
// value       in   16  digit3=[15:12] .. digit0=[3:0], hex
// dp          in   4   decimal point per digit, 1=lit
// lz_blank    in   1   1=blank leading zero digits (level, sampled live)
// an          out  4   anodes, active-low, one-hot-low when lit
// leds        out  7   segments {g,f,e,d,c,b,a}, active-low
// dp_n        out  1   decimal point, active-low
// frame_done  out  1   1-cycle pulse at end of each 4-digit frame
// BEHAVIOUR
// - Reset (reset=0, async): presc=0, idx=0, disp_val=0, disp_dp=0, pend=0; an=4'b1111, leds=7'h7F, dp_n=1, frame_done=0.
// - presc counts 0..CLK_DIV-1 and wraps to 0; tick=(presc==CLK_DIV-1).
// - On tick: idx<=idx+1 mod 4 (3->0 wraps).
// - Boundary = tick & idx==3; frame_done is registered, high the cycle after boundary.
// - load: shadow_val<=value, shadow_dp<=dp, pend<=1. Later loads overwrite shadow (last wins).
// - At boundary with pend=1: disp_val<=shadow_val, disp_dp<=shadow_dp, pend<=0.
// - load in same cycle as boundary: value/dp commit directly to disp_*; pend stays 0.
// - Otherwise disp_* hold; a load never alters the frame in progress.
// - an/leds/dp_n are registered from idx and disp_*, and change exactly 1 clk after idx/disp_* change.
// - Lit digit i: an=~(4'b1<<i), leds=hex7(nibble i), dp_n=~disp_dp[i].
// - Leading-zero blanking (lz_blank=1): digit i (i=3..1) is blank if nibble i and all higher nibbles are 0.
//   Digit 0 is never blanked.
// - Blank slot: an=4'b1111, leds=7'h7F, dp_n=1; the slot still occupies its full CLK_DIV time.
// - hex7 (active-low):
//   0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//   8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
// - Reset asserted mid-frame: all state clears immediately, and the pending shadow is discarded.
//   After release, scan restarts at digit0 with presc=0.
// - No X on outputs after reset. All state lives in the clk domain; the inputs are synchronous to clk.
// TESTING (CLK_DIV=4)
// - Reset held low, then released -> an=1111, leds=7F until first update.
//   Afterwards digit0 shows 0: an=1110, leds=40, dp_n=1; idx steps every 4 clks.
// - load value=16'h1234 mid-frame -> current frame still shows 0000.
//   After frame_done: digit0 an=1110 leds=19, digit1 an=1101 leds=30,
//   digit2 an=1011 leds=24, digit3 an=0111 leds=79.
// - load 16'hAAAA then 16'h00F0 in the same frame -> next frame shows 00F0 only (digit1 leds=0E); no AAAA frame appears.
// - load 16'h5678 on the exact boundary cycle -> the following frame shows 5678 with no extra frame delay.
// - lz_blank=1, value=16'h0050, dp=4'b0001 -> digit3/digit2 an=1111, leds=7F;
//   digit1 leds=12; digit0 leds=40, dp_n=0.
//   With value=16'h0000 -> only digit0 lit, leds=40.
// - Assert reset for 1 clk mid-frame with a pending load -> outputs go to reset values asynchronously.
//   After release the display shows 0000 and the pending value is lost.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bus-side write strobe, digit data and frame status for the scan driver
interface seg7_scan_driver_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_blank;
  logic        frame_done;
  modport master (output load, value, dp, lz_blank, input frame_done);
  modport slave  (input load, value, dp, lz_blank, output frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed seven-segment driver with frame-aligned commit
module seg7_scan_driver #(
  parameter int CLK_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   bus,
  output logic [3:0]          an,
  output logic [6:0]          leds,
  output logic                dp_n
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [6:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   shadow_val, disp_val;
  logic [3:0]    shadow_dp, disp_dp;
  logic          pend, tick, boundary, blank;
  logic [3:0]    nib;
  assign tick     = presc == LAST;
  assign boundary = tick && idx == 2'd3;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      presc          <= '0;
      idx            <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      presc          <= tick ? '0 : presc + PW'(1);
      idx            <= idx + 2'(tick);
      bus.frame_done <= boundary;
    end
  // A load coinciding with the boundary goes straight to the display, skipping the shadow
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend       <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp;
      end
      if (boundary && bus.load) begin
        disp_val <= bus.value;
        disp_dp  <= bus.dp;
        pend     <= 1'b0;
      end else if (boundary && pend) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pend     <= 1'b0;
      end else if (bus.load) begin
        pend <= 1'b1;
      end
    end
  // Digit i is a leading zero when every nibble from i upward is zero
  always_comb begin
    nib   = disp_val[{idx, 2'b00} +: 4];
    blank = bus.lz_blank && idx != 2'd0 && (disp_val >> {idx, 2'b00}) == 16'd0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      an   <= 4'hF;
      leds <= 7'h7F;
      dp_n <= 1'b1;
    end else begin
      an   <= blank ? 4'hF : ~(4'b0001 << idx);
      leds <= blank ? 7'h7F : HEX7[nib];
      dp_n <= blank | ~disp_dp[idx];
    end
endmodule
